// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared LC-3b word/line types and arbiter state encoding
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_block;
    typedef enum logic [1:0] {IDLE, BUSY, TURN} arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational fixed-priority / round-robin winner picker
module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int MODE      = 1,
    parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] active,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 any_active
);
    always_comb begin
        int idx;
        idx        = 0;
        winner     = '0;
        any_active = |active;
        if (MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (active[IDX_WIDTH'(i)]) winner = IDX_WIDTH'(i);
            end
        end else begin
            // Scan from farthest to nearest so the port right after last_grant wins last.
            for (int k = NUM_PORTS; k >= 1; k--) begin
                idx = (int'(last_grant) + k) % NUM_PORTS;
                if (active[IDX_WIDTH'(idx)]) winner = IDX_WIDTH'(idx);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port L1-to-L2 arbiter with per-transaction grant latching
module mem_arbiter_rr
    import lc3b_types::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = $bits(lc3b_word),
    parameter int BLOCK_WIDTH = $bits(lc3b_c_block),
    parameter int ARB_MODE    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [BLOCK_WIDTH-1:0]           req_rdata,
    output logic                             l2_read,
    output logic                             l2_write,
    output logic [ADDR_WIDTH-1:0]            l2_address,
    output logic [BLOCK_WIDTH-1:0]           l2_wdata,
    input  logic [BLOCK_WIDTH-1:0]           l2_rdata,
    input  logic                             l2_resp,
    output logic                             busy,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id
);
    localparam int IW = $clog2(NUM_PORTS);

    arb_state_t              state;
    logic [IW-1:0]           grant;
    logic [IW-1:0]           last_grant;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BLOCK_WIDTH-1:0]  wdata_q;
    logic [NUM_PORTS-1:0]    active;
    logic [IW-1:0]           winner;
    logic                    any_active;
    logic                    resp_fire;

    assign active = req_read | req_write;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (ARB_MODE),
        .IDX_WIDTH (IW)
    ) u_pick (
        .active     (active),
        .last_grant (last_grant),
        .winner     (winner),
        .any_active (any_active)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_PORTS - 1);
            addr_q     <= '0;
            wdata_q    <= '0;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_active) begin
                        // A read+write port is treated as a write.
                        grant    <= winner;
                        addr_q   <= req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q  <= req_wdata[int'(winner)*BLOCK_WIDTH +: BLOCK_WIDTH];
                        l2_read  <= ~req_write[winner];
                        l2_write <= req_write[winner];
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (l2_resp) begin
                        last_grant <= grant;
                        l2_read    <= 1'b0;
                        l2_write   <= 1'b0;
                        state      <= TURN;
                    end
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state == BUSY);
    assign resp_fire  = busy & l2_resp;
    assign grant_id   = grant;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign req_rdata  = resp_fire ? l2_rdata : '0;

    always_comb begin
        req_resp = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_resp[i] = resp_fire & (grant == IW'(i));
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - directed bench for mem_arbiter_rr in 2-port RR, 4-port RR and 4-port fixed modes
module tb_mem_arbiter_rr;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_read  = '0;
    logic [3:0]   req_write = '0;
    logic [63:0]  req_address = '0;
    logic [511:0] req_wdata = '0;
    logic [127:0] l2_rdata = '0;
    logic         a_l2_resp = 1'b0, b_l2_resp = 1'b0, c_l2_resp = 1'b0;

    logic [1:0]   a_req_resp;
    logic [127:0] a_req_rdata, a_l2_wdata;
    logic         a_l2_read, a_l2_write, a_busy;
    logic [15:0]  a_l2_address;
    logic [0:0]   a_grant_id;

    logic [3:0]   b_req_resp, c_req_resp;
    logic [127:0] b_req_rdata, b_l2_wdata, c_req_rdata, c_l2_wdata;
    logic         b_l2_read, b_l2_write, b_busy, c_l2_read, c_l2_write, c_busy;
    logic [15:0]  b_l2_address, c_l2_address;
    logic [1:0]   b_grant_id, c_grant_id;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.NUM_PORTS(2), .ARB_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .req_read(req_read[1:0]), .req_write(req_write[1:0]),
        .req_address(req_address[31:0]), .req_wdata(req_wdata[255:0]),
        .req_resp(a_req_resp), .req_rdata(a_req_rdata), .l2_read(a_l2_read), .l2_write(a_l2_write),
        .l2_address(a_l2_address), .l2_wdata(a_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(a_l2_resp),
        .busy(a_busy), .grant_id(a_grant_id)
    );

    mem_arbiter_rr #(.NUM_PORTS(4), .ARB_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(b_req_resp), .req_rdata(b_req_rdata), .l2_read(b_l2_read), .l2_write(b_l2_write),
        .l2_address(b_l2_address), .l2_wdata(b_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(b_l2_resp),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    mem_arbiter_rr #(.NUM_PORTS(4), .ARB_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(c_req_resp), .req_rdata(c_req_rdata), .l2_read(c_l2_read), .l2_write(c_l2_write),
        .l2_address(c_l2_address), .l2_wdata(c_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(c_l2_resp),
        .busy(c_busy), .grant_id(c_grant_id)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
        a_l2_resp = 1'b0; b_l2_resp = 1'b0; c_l2_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({a_req_resp, a_l2_read, a_l2_write, a_busy, a_grant_id} !== 6'b0 || a_l2_address !== 16'h0 || a_l2_wdata !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_a: resp=%b rd=%b wr=%b busy=%b gid=%0d addr=%h expected all zero",
                     a_req_resp, a_l2_read, a_l2_write, a_busy, a_grant_id, a_l2_address);
        end
        vectors++;
        if ({b_req_resp, b_l2_read, b_busy, b_grant_id, c_req_resp, c_l2_write, c_busy, c_grant_id} !== 16'b0) begin
            miscompares++;
            $display("FAIL reset_bc: b_resp=%b b_gid=%0d c_resp=%b c_gid=%0d expected all zero",
                     b_req_resp, b_grant_id, c_req_resp, c_grant_id);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_read();
        do_reset();
        req_read[0] = 1'b1;
        req_address[15:0] = 16'h1230;
        #1;
        vectors++;
        if (a_l2_read !== 1'b0) begin
            miscompares++;
            $display("FAIL no_comb_path: l2_read=%b expected 0 before the clock edge", a_l2_read);
        end
        @(negedge clk);
        vectors++;
        if (a_l2_read !== 1'b1 || a_l2_write !== 1'b0 || a_l2_address !== 16'h1230 || a_busy !== 1'b1 || a_grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL read_issue: rd=%b wr=%b addr=%h busy=%b gid=%0d expected 1 0 1230 1 0",
                     a_l2_read, a_l2_write, a_l2_address, a_busy, a_grant_id);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (a_l2_read !== 1'b1 || a_req_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL read_hold: rd=%b resp=%b expected 1 00", a_l2_read, a_req_resp);
        end
        l2_rdata = {8{16'hDEAD}};
        a_l2_resp = 1'b1;
        #1;
        vectors++;
        if (a_req_resp !== 2'b01 || a_req_rdata !== {8{16'hDEAD}}) begin
            miscompares++;
            $display("FAIL read_resp: resp=%b rdata=%h expected 01 %h", a_req_resp, a_req_rdata, {8{16'hDEAD}});
        end
        @(negedge clk);
        a_l2_resp = 1'b0;
        req_read = '0;
        #1;
        vectors++;
        if (a_l2_read !== 1'b0 || a_busy !== 1'b0 || a_req_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL read_turn: rd=%b busy=%b resp=%b expected 0 0 00", a_l2_read, a_busy, a_req_resp);
        end
    endtask

    task automatic test_rr_rotation();
        int cnt [4] = '{0, 0, 0, 0};
        int exp_id;
        int n;
        do_reset();
        req_read = 4'hF;
        for (int t = 0; t < 5; t++) begin
            exp_id = t % 4;
            n = 0;
            while (!b_busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (!b_busy) begin
                miscompares++;
                $display("FAIL rr_timeout: txn %0d busy=%b expected 1 within 10 cycles", t, b_busy);
            end
            vectors++;
            if (b_grant_id !== 2'(exp_id)) begin
                miscompares++;
                $display("FAIL rr_grant: txn %0d grant_id=%0d expected %0d", t, b_grant_id, exp_id);
            end
            b_l2_resp = 1'b1;
            #1;
            vectors++;
            if (b_req_resp !== (4'b0001 << exp_id)) begin
                miscompares++;
                $display("FAIL rr_resp: txn %0d req_resp=%b expected %b", t, b_req_resp, 4'b0001 << exp_id);
            end
            for (int i = 0; i < 4; i++) if (b_req_resp[i]) cnt[i]++;
            if (t == 3) begin
                vectors++;
                if (cnt[0] != 1 || cnt[1] != 1 || cnt[2] != 1 || cnt[3] != 1) begin
                    miscompares++;
                    $display("FAIL rr_fair: pulse counts %0d %0d %0d %0d expected 1 1 1 1", cnt[0], cnt[1], cnt[2], cnt[3]);
                end
            end
            @(negedge clk);
            b_l2_resp = 1'b0;
            if (t == 4) req_read = '0;
        end
    endtask

    task automatic test_fixed_priority();
        int n;
        int exp_id;
        do_reset();
        req_read = 4'b0110;
        for (int t = 0; t < 4; t++) begin
            exp_id = (t < 3) ? 1 : 2;
            n = 0;
            while (!c_busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (c_grant_id !== 2'(exp_id) || !c_busy) begin
                miscompares++;
                $display("FAIL fixed_grant: txn %0d grant_id=%0d busy=%b expected %0d 1", t, c_grant_id, c_busy, exp_id);
            end
            c_l2_resp = 1'b1;
            #1;
            vectors++;
            if (c_req_resp !== (4'b0001 << exp_id)) begin
                miscompares++;
                $display("FAIL fixed_resp: txn %0d req_resp=%b expected %b", t, c_req_resp, 4'b0001 << exp_id);
            end
            @(negedge clk);
            c_l2_resp = 1'b0;
            if (t == 2) req_read[1] = 1'b0;
            if (t == 3) req_read = '0;
        end
    endtask

    task automatic test_write_hold();
        int n;
        do_reset();
        req_write[1] = 1'b1;
        req_address[31:16] = 16'h4000;
        req_wdata[255:128] = {16{8'hA5}};
        n = 0;
        while (!a_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!a_busy || a_grant_id !== 1'b1) begin
            miscompares++;
            $display("FAIL write_grant: busy=%b grant_id=%0d expected 1 1", a_busy, a_grant_id);
        end
        req_address[31:16] = 16'h5000;
        req_wdata[255:128] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (a_l2_write !== 1'b1 || a_l2_read !== 1'b0 || a_l2_address !== 16'h4000 || a_l2_wdata !== {16{8'hA5}}) begin
                miscompares++;
                $display("FAIL write_hold: cyc %0d wr=%b rd=%b addr=%h wdata=%h expected 1 0 4000 a5..a5",
                         c, a_l2_write, a_l2_read, a_l2_address, a_l2_wdata);
            end
        end
        a_l2_resp = 1'b1;
        #1;
        vectors++;
        if (a_req_resp !== 2'b10) begin
            miscompares++;
            $display("FAIL write_resp: req_resp=%b expected 10", a_req_resp);
        end
        @(negedge clk);
        a_l2_resp = 1'b0;
        req_write = '0;
    endtask

    task automatic test_reset_mid_busy();
        int n;
        do_reset();
        req_read[1] = 1'b1;
        req_address[31:16] = 16'h2222;
        n = 0;
        while (!a_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        a_l2_resp = 1'b1;
        #1;
        vectors++;
        if (a_l2_read !== 1'b0 || a_busy !== 1'b0 || a_grant_id !== 1'b0 || a_req_resp !== 2'b00 || a_l2_address !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset: rd=%b busy=%b gid=%0d resp=%b addr=%h expected 0 0 0 00 0000",
                     a_l2_read, a_busy, a_grant_id, a_req_resp, a_l2_address);
        end
        @(negedge clk);
        rst = 1'b0;
        a_l2_resp = 1'b0;
        req_read[1:0] = 2'b11;
        req_address[15:0] = 16'h3333;
        n = 0;
        while (!a_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!a_busy || a_grant_id !== 1'b0 || a_l2_address !== 16'h3333 || a_req_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_grant: busy=%b gid=%0d addr=%h resp=%b expected 1 0 3333 00",
                     a_busy, a_grant_id, a_l2_address, a_req_resp);
        end
        a_l2_resp = 1'b1;
        #1;
        vectors++;
        if (a_req_resp !== 2'b01) begin
            miscompares++;
            $display("FAIL post_reset_resp: req_resp=%b expected 01", a_req_resp);
        end
        @(negedge clk);
        a_l2_resp = 1'b0;
        req_read = '0;
    endtask

    task automatic test_spurious_and_dual();
        int n;
        do_reset();
        a_l2_resp = 1'b1;
        #1;
        vectors++;
        if (a_req_resp !== 2'b00 || a_req_rdata !== 128'h0) begin
            miscompares++;
            $display("FAIL spurious_idle: req_resp=%b rdata=%h expected 00 0", a_req_resp, a_req_rdata);
        end
        @(negedge clk);
        a_l2_resp = 1'b0;
        req_read[0] = 1'b1;
        req_write[0] = 1'b1;
        req_address[15:0] = 16'h0ABC;
        n = 0;
        while (!a_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (a_l2_write !== 1'b1 || a_l2_read !== 1'b0 || a_l2_address !== 16'h0ABC) begin
            miscompares++;
            $display("FAIL dual_request: wr=%b rd=%b addr=%h expected 1 0 0abc", a_l2_write, a_l2_read, a_l2_address);
        end
        a_l2_resp = 1'b1;
        #1;
        vectors++;
        if (a_req_resp !== 2'b01) begin
            miscompares++;
            $display("FAIL dual_resp: req_resp=%b expected 01", a_req_resp);
        end
        @(negedge clk);
        req_read = '0;
        req_write = '0;
        #1;
        vectors++;
        if (a_req_resp !== 2'b00 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_turn: req_resp=%b busy=%b expected 00 0", a_req_resp, a_busy);
        end
        @(negedge clk);
        a_l2_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_rr_rotation();
        test_fixed_priority();
        test_write_hold();
        test_reset_mid_busy();
        test_spurious_and_dual();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-port memory arbiter between N L1 requestors (icache, dcache, future prefetch/victim ports) and the single L2 cache port.
- Generalises the fixed two-port icache/dcache arbiter in three ways: NUM_PORTS channels, a selectable fixed-priority or round-robin mode, and read/write on every port.
- Grant is latched per transaction and held until L2 responds. The response is steered back to the granted port only.

Parameters:
- NUM_PORTS, 2, number of requestor channels (2..8).
- ADDR_WIDTH, 16, address width (lc3b_word).
- BLOCK_WIDTH, 128, line width (lc3b_c_block).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_read  in  NUM_PORTS  per-port read request.
- req_write  in  NUM_PORTS  per-port write request.
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*BLOCK_WIDTH  per-port write line, packed the same way.
- req_resp  out  NUM_PORTS  per-port completion pulse.
- req_rdata  out  BLOCK_WIDTH  read line, broadcast to all ports; valid only with req_resp.
- l2_read  out  1  L2 read command.
- l2_write  out  1  L2 write command.
- l2_address  out  ADDR_WIDTH  L2 address.
- l2_wdata  out  BLOCK_WIDTH  L2 write line.
- l2_rdata  in  BLOCK_WIDTH  L2 read line.
- l2_resp  in  1  L2 completion.
- busy  out  1  a transaction is in flight (state BUSY); drives pipeline load_regs gating.
- grant_id  out  $clog2(NUM_PORTS)  index of the current or last granted port.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - All outputs are 0: req_resp, l2_read, l2_write, l2_address, l2_wdata, busy, grant_id.
  - last_grant = NUM_PORTS-1, so port 0 is first in round-robin.
  - Reset while in BUSY abandons the transaction; no req_resp is issued.
- States: IDLE, BUSY, TURN.
- IDLE:
  - A port is active when req_read[i] | req_write[i].
  - If any port is active, select a winner:
    - ARB_MODE 0: lowest active index.
    - ARB_MODE 1: first active index scanning last_grant+1, last_grant+2, ..., modulo NUM_PORTS.
  - On the next clock edge, latch the winner's index, address, wdata and op (write = req_write[winner]), then go to BUSY.
  - If no port is active, stay in IDLE.
  - Latency: request seen in IDLE at cycle 0 -> l2 command asserted from cycle 1.
- BUSY:
  - l2_read = ~op_write and l2_write = op_write, both held.
  - l2_address and l2_wdata come from the latched copies, so later requestor changes are ignored.
  - busy = 1.
  - On l2_resp = 1, in the same cycle (combinational):
    - req_resp[grant] = 1 and req_rdata = l2_rdata.
    - All other req_resp bits stay 0.
  - On l2_resp, last_grant <= grant and the next state is TURN.
- TURN:
  - One cycle with no l2 command and busy = 0.
  - Lets the served requestor drop its request, avoiding a duplicate grant.
  - Next state is IDLE.
- Protocol rules:
  - A requestor holds read/write, address and wdata until its req_resp.
  - req_read and req_write both high on one port: treat as a write.
  - A request dropped during BUSY: the transaction still completes and req_resp still pulses.
  - l2_resp in IDLE or TURN is ignored; no req_resp.
- Fairness:
  - In RR mode, a continuously requesting port waits at most NUM_PORTS-1 transactions.
  - In fixed mode, starvation is permitted by design.
- Widths and timing:
  - grant_id is zero-extended; the modulo wrap in the RR scan is explicit.
  - No combinational path from req_* inputs to l2_* outputs; all l2 outputs are registered or driven from latched state.

Decomposition:
- Package lc3b_types: existing lc3b_word and lc3b_c_block; add enum arb_state_t {IDLE, BUSY, TURN}.
- Sub-module rr_pick (parametrised NUM_PORTS, MODE):
  - Combinational priority or round-robin picker.
  - Inputs: active vector, last_grant.
  - Outputs: winner index, any_active.
  - Unit-testable on its own.

Test Plan:
1. Reset, then port 0 read at addr 0x1230 → l2_read=1 with l2_address=0x1230 from cycle 1. L2 returns l2_rdata=0xDEAD... after 5 cycles → req_resp=2'b01 that cycle with req_rdata=0xDEAD...; next cycle TURN with l2_read=0.
2. NUM_PORTS=4, RR, all ports reading continuously → grant_id sequence 0,1,2,3,0; each req_resp bit pulses once per 4 transactions.
3. ARB_MODE=0, ports 1 and 2 requesting continuously → only port 1 is ever granted; port 2 gets req_resp only after port 1 deasserts.
4. Port 1 write with wdata=0xA5..A5, addr 0x4000; the requestor changes its address to 0x5000 mid-BUSY → l2_write=1, l2_address stays 0x4000, l2_wdata=0xA5..A5 until l2_resp.
5. rst pulsed mid-BUSY on port 1 → all outputs 0 immediately (async); after release, a simultaneous request from ports 0 and 1 grants port 0 first; no stale req_resp.
6. Spurious l2_resp in IDLE, and a port with both read and write high → no req_resp for the spurious l2_resp; the dual request issues l2_write=1, l2_read=0.
